// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: control FSM encoding, stage-control bundle and the
// bubble field values that IF_ID / ID_EX / EX_MEM load when flushed.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    // Field values a flushed pipeline register must carry so the slot is inert
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [4:0]  BUBBLE_RD        = 5'd0;
    localparam logic        BUBBLE_MEM_WRITE = 1'b0;
    localparam logic        BUBBLE_REG_WRITE = 1'b0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NORMAL = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
        id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1
    };

    localparam stage_ctrl_t CTRL_FREEZE = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
        id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0
    };

    localparam stage_ctrl_t CTRL_REDIRECT = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
        id_ex_en: 1'b1, id_ex_flush: 1'b1, ex_mem_en: 1'b1
    };

    // IF and ID hold while ID_EX takes a bubble: exactly one slot of delay
    localparam stage_ctrl_t CTRL_LOAD_USE = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
        id_ex_en: 1'b1, id_ex_flush: 1'b1, ex_mem_en: 1'b1
    };

    // Held in reset the registers still clock, so they must load bubbles
    localparam stage_ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
        id_ex_en: 1'b0, id_ex_flush: 1'b1, ex_mem_en: 1'b0
    };

    function automatic int wait_cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w > 8) ? w : 8;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath and its stall/flush controller.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_use_rs1_i;
    logic             id_use_rs2_i;
    logic [4:0]       ex_rd_i;
    logic             ex_is_load_i;
    logic             ex_redirect_i;
    logic             mem_req_i;
    logic             mem_ready_i;

    logic             pc_en_o;
    logic             if_id_en_o;
    logic             if_id_flush_o;
    logic             id_ex_en_o;
    logic             id_ex_flush_o;
    logic             ex_mem_en_o;
    logic             state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             mem_timeout_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_i, ex_is_load_i, ex_redirect_i, mem_req_i, mem_ready_i,
        input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
               ex_mem_en_o, state_o, stall_cnt_o, flush_cnt_o, mem_timeout_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_i, ex_is_load_i, ex_redirect_i, mem_req_i, mem_ready_i,
        output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
               ex_mem_en_o, state_o, stall_cnt_o, flush_cnt_o, mem_timeout_o
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator between the instruction in ID and a load in EX.
// Purely combinational; x0 as a destination never creates a dependency.
module hazard_detect (
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_is_load_i,
    output logic       hazard_o
);

    logic rs1_match;
    logic rs2_match;
    logic rd_valid;

    always_comb begin
        rd_valid  = ex_is_load_i && (ex_rd_i != 5'd0);
        rs1_match = id_use_rs1_i && (id_rs1_i == ex_rd_i);
        rs2_match = id_use_rs2_i && (id_rs2_i == ex_rd_i);
        hazard_o  = rd_valid && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline stall/flush controller: priority mux over freeze, redirect
// and load-use, a RUN/MEM_WAIT FSM with memory watchdog, and saturating counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
);

    localparam int                WAIT_W       = wait_cnt_width(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT_V = WAIT_W'(WAIT_LIMIT);

    logic              freeze;
    logic              hazard;
    logic              redirect_applied;
    stage_ctrl_t       ctrl;

    state_e            state_q;
    state_e            state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              mem_timeout_q;
    logic              mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
        return (v >= WAIT_LIMIT_V) ? v : v + 1'b1;
    endfunction

    hazard_detect u_hazard (
        .id_rs1_i     (bus.id_rs1_i),
        .id_rs2_i     (bus.id_rs2_i),
        .id_use_rs1_i (bus.id_use_rs1_i),
        .id_use_rs2_i (bus.id_use_rs2_i),
        .ex_rd_i      (bus.ex_rd_i),
        .ex_is_load_i (bus.ex_is_load_i),
        .hazard_o     (hazard)
    );

    assign freeze = bus.mem_req_i && !bus.mem_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (freeze) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (bus.mem_ready_i || !bus.mem_req_i) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    // A redirect raised while frozen is simply re-seen once the freeze lifts,
    // because the EX stage is held and keeps presenting it.
    always_comb begin
        ctrl             = CTRL_NORMAL;
        redirect_applied = 1'b0;
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end else if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (bus.ex_redirect_i) begin
            ctrl             = CTRL_REDIRECT;
            redirect_applied = 1'b1;
        end else if (hazard) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    // The wait count tracks frozen cycles including the entry cycle, so the
    // flag is already visible during the WAIT_LIMIT-th cycle spent in MEM_WAIT.
    always_comb begin
        wait_cnt_d    = '0;
        if (state_d == ST_MEM_WAIT) begin
            wait_cnt_d = wait_inc(wait_cnt_q);
        end
        mem_timeout_d = mem_timeout_q || (wait_cnt_d == WAIT_LIMIT_V);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ctrl.pc_en) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (redirect_applied) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign bus.pc_en_o       = ctrl.pc_en;
    assign bus.if_id_en_o    = ctrl.if_id_en;
    assign bus.if_id_flush_o = ctrl.if_id_flush;
    assign bus.id_ex_en_o    = ctrl.id_ex_en;
    assign bus.id_ex_flush_o = ctrl.id_ex_flush;
    assign bus.ex_mem_en_o   = ctrl.ex_mem_en;
    assign bus.state_o       = (state_q == ST_MEM_WAIT);
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;
    assign bus.mem_timeout_o = mem_timeout_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the stall and flush performance counters.
REQ-002 Parameter WAIT_LIMIT, default 255, SHALL set the number of consecutive MEM_WAIT cycles after which the watchdog trips.
REQ-003 Ports SHALL be as follows:
  clk  in  1  clock; all state updates on the rising edge
  rst_n  in  1  reset; asynchronous, active-low
  id_rs1_i  in  5  rs1 address of the instruction in ID
  id_rs2_i  in  5  rs2 address of the instruction in ID
  id_use_rs1_i  in  1  ID instruction reads rs1
  id_use_rs2_i  in  1  ID instruction reads rs2
  ex_rd_i  in  5  destination register of the instruction in EX
  ex_is_load_i  in  1  EX instruction is a load
  ex_redirect_i  in  1  branch/jump taken in EX, so the PC loads the target
  mem_req_i  in  1  MEM stage is issuing a data-memory access
  mem_ready_i  in  1  data memory completes the access this cycle
  pc_en_o  out  1  PC register update enable
  if_id_en_o  out  1  IF_ID load enable
  if_id_flush_o  out  1  IF_ID loads a NOP/bubble
  id_ex_en_o  out  1  ID_EX load enable
  id_ex_flush_o  out  1  ID_EX loads a bubble (mem_write=0, rd=0)
  ex_mem_en_o  out  1  EX_MEM load enable
  state_o  out  1  0=RUN, 1=MEM_WAIT
  stall_cnt_o  out  CNT_W  saturating count of cycles with pc_en_o=0
  flush_cnt_o  out  CNT_W  saturating count of accepted redirects
  mem_timeout_o  out  1  sticky watchdog flag

Function
REQ-004 The enable and flush outputs SHALL be combinational functions of the inputs and the state, taking effect in the same cycle; the counters, the state and mem_timeout_o SHALL be registered.
REQ-005 freeze = mem_req_i AND NOT mem_ready_i; when freeze=1, pc_en_o, if_id_en_o, id_ex_en_o and ex_mem_en_o SHALL all be 0 and both flushes SHALL be 0.
REQ-006 A load-use hazard exists when ex_is_load_i=1, ex_rd_i!=0, and either (id_use_rs1_i and id_rs1_i==ex_rd_i) or (id_use_rs2_i and id_rs2_i==ex_rd_i).
REQ-007 Redirect (freeze=0, ex_redirect_i=1) SHALL drive pc_en_o=1, if_id_en_o=1, if_id_flush_o=1, id_ex_en_o=1, id_ex_flush_o=1 and ex_mem_en_o=1.
REQ-008 Load-use (freeze=0, ex_redirect_i=0, hazard=1) SHALL drive pc_en_o=0, if_id_en_o=0, id_ex_en_o=1, id_ex_flush_o=1 and ex_mem_en_o=1, which inserts exactly one bubble.
REQ-009 Priority SHALL be freeze > redirect > load-use > normal; a redirect coincident with a load-use hazard SHALL discard the hazard stall.
REQ-010 Normal operation SHALL drive all enables to 1 and all flushes to 0.
REQ-011 State transitions: RUN->MEM_WAIT when freeze=1; MEM_WAIT->RUN on the first cycle with mem_ready_i=1 or mem_req_i=0; otherwise the state SHALL hold.
REQ-012 A wait counter of 8 bits minimum SHALL clear on entry to RUN and increment on each MEM_WAIT cycle; when it reaches WAIT_LIMIT, mem_timeout_o SHALL set and stay set until reset.
REQ-013 stall_cnt_o SHALL increment each cycle in which pc_en_o=0; flush_cnt_o SHALL increment each cycle in which a redirect is applied (REQ-007); both SHALL saturate at all-ones and never wrap.
REQ-014 A redirect held during freeze SHALL be applied on the first unfrozen cycle, without being latched, because ID_EX/EX_MEM are frozen and ex_redirect_i persists.

Reset
REQ-015 While rst_n=0: state=RUN, counters=0, wait counter=0, mem_timeout_o=0; all *_en_o=0; if_id_flush_o=1 and id_ex_flush_o=1, so unreset pipeline registers load bubbles on clocks during reset.
REQ-016 Reset asserted mid-MEM_WAIT SHALL abort the wait immediately; after deassertion the block SHALL resume in RUN on the next rising edge.

Structure
REQ-017 The state encoding (RUN/MEM_WAIT) and the bubble field values SHALL live in the shared pipeline package, to be reused by IF_ID/ID_EX/EX_MEM integration.
REQ-018 Hazard comparison SHALL be a sub-module, hazard_detect, that is purely combinational; the FSM, the counters and the priority mux SHALL stay in pipe_ctrl.

Verification
REQ-019 Scenario: load x5 in EX, ID reads rs1=x5 -> for one cycle pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, and stall_cnt_o goes 0->1.
REQ-020 Scenario: load x0 in EX, ID reads x0 -> no stall, all enables 1.
REQ-021 Scenario: ex_redirect_i=1 concurrent with a load-use hazard -> both flushes 1, pc_en_o=1, flush_cnt_o=1, stall_cnt_o unchanged.
REQ-022 Scenario: mem_req_i=1, mem_ready_i=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, state_o=1 for 3 cycles, RUN after ready.
REQ-023 Scenario: WAIT_LIMIT=4, ready withheld 10 cycles -> mem_timeout_o rises on the 4th wait cycle and stays 1 until rst_n=0.
REQ-024 Scenario: CNT_W=4, 20 stall cycles -> stall_cnt_o holds at 15; rst_n pulsed mid-wait -> all outputs match REQ-015 immediately.
